mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the shared byte-addressed data memory (`Memory_byteaddress`, 12-bit address, 4 byte enables, 1-cycle synchronous read). It sits between the RISC-V core's load/store port and the UART program loader. It grants the memory to one requester at a time, returns read data with a one-cycle acknowledge, and stalls the core while `prog` is asserted.

## Interface
- `ADDR_W`, 12, memory byte-address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `clk`  in  1  system clock; all state updates on its rising edge
- `Rst`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `prog`  in  1  program mode; when 1 the loader owns memory and core requests are ignored
- `c_req`  in  1  core access request; held high until `c_ack`
- `c_we`  in  1  core write (1) / read (0)
- `c_be`  in  DATA_W/8  core byte enables
- `c_addr`  in  ADDR_W  core byte address
- `c_wdata`  in  DATA_W  core write data
- `c_ack`  out  1  one-cycle completion pulse to core
- `c_rdata`  out  DATA_W  core read data, registered, held until next core read completes
- `c_stall`  out  1  core pipeline stall
- `l_req`, `l_we`, `l_be`, `l_addr`, `l_wdata`  in  (same widths)  loader request bundle, same rules as core
- `l_ack`  out  1  loader completion pulse
- `l_rdata`  out  DATA_W  loader read data, registered
- `mem_wea`  out  1  memory write enable
- `mem_en`  out  DATA_W/8  memory byte enables
- `mem_addr`  out  ADDR_W  memory address
- `mem_din`  out  DATA_W  memory write data
- `mem_dout`  in  DATA_W  memory read data, valid the cycle after a read issue
- `owner`  out  1  granted requester of the current/last transaction: 0 core, 1 loader
- `busy`  out  1  high in ISSUE and RESP

## Operation
- FSM: IDLE -> ISSUE -> RESP -> IDLE. One transaction in flight at a time.
- IDLE: sample `prog`, `c_req`, `l_req`. Eligible core = `c_req & !prog`; eligible loader = `l_req`.
  - Only one eligible: grant it.
  - Both eligible: round-robin. Grant the requester not granted last (`last_grant` register).
  - On grant, capture we/be/addr/wdata into internal registers, set `owner`, go to ISSUE.
  - None eligible: stay in IDLE.
- ISSUE: drive `mem_en`=captured be, `mem_wea`=captured we, `mem_addr`, `mem_din` from the capture registers. Go to RESP.
- RESP: pulse the owner's ack.
  - Read: load the owner's rdata register from `mem_dout`.
  - Write: rdata is unchanged.
  - Update `last_grant`, then go to IDLE.
- Outside ISSUE: `mem_en`=0, `mem_wea`=0; `mem_addr` and `mem_din` hold their captured values.
- A request with `be`=0 is a legal no-op. It sequences normally with `mem_en`=0, is acknowledged, and rdata is not updated.
- `c_stall` = `prog | (c_req & !c_ack)` (combinational).
- `prog` is evaluated only in IDLE. An in-flight core transaction always completes when `prog` rises. An in-flight loader transaction completes when `prog` falls.
- The requester must drop req in the cycle after its ack. A req still high in IDLE is a new transaction.

## Timing
- Reset (`Rst`=0, async): state IDLE, all outputs 0, `last_grant`=1 (loader), so the core wins the first tie. Reset mid-transaction aborts it: `mem_en`/`mem_wea` drop immediately, no ack is issued, rdata registers are cleared.
- Req high at cycle t (state IDLE): issue at t+1, ack at t+2, rdata valid at t+2 (read). Latency is 2 cycles after the sampling edge.
- Throughput: one access per 3 cycles. No bubble beyond IDLE.
- Address and data widths pass through unchanged; no address arithmetic or wrap.
- Core and loader req arriving in the same IDLE cycle: resolved by round-robin, never both granted.

## Test plan
- Core write then read: `c_we`=1, addr 0x010, be 4'hF, data 0xDEADBEEF, then a read of 0x010. Expect `mem_en`=F at t+1, `c_ack` at t+2, and `c_rdata`=0xDEADBEEF after the read ack.
- Byte write: write 0x11223344 to 0x020, then be 4'b0010 with data 0x0000AA00, then read. Expect 0x1122AA44.
- Contention, `prog`=0: `c_req` and `l_req` held together for 4 transactions after reset. Grants alternate core, loader, core, loader; each gets exactly one ack per transaction.
- Program mode: `prog`=1, core read pending, loader writes 0x000..0x00C. Expect `c_stall`=1 and no `c_ack` throughout. Drop `prog`: core is granted in the next IDLE and reads the loaded word.
- `prog` rises during a core ISSUE: the core transaction completes with `c_ack` at RESP; the next grant goes to the loader.
- `Rst`=0 pulse during ISSUE: `mem_en` drops to 0 asynchronously, no ack follows, all outputs are 0. After release, a new core read completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants the shared byte-addressed data memory to either
// the core load/store port or the UART program loader, one access at a time.
// Each access is IDLE -> ISSUE -> RESP: the request is captured in IDLE, driven
// to the memory in ISSUE, and acknowledged in RESP while the read data arrives.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | arbitrate; capture the winning request bundle
// ISSUE  | memory strobes driven from the capture registers
// RESP   | owner's ack pulses; read data lands in the owner's rdata register
module mem_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  prog,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [DATA_W/8-1:0]   c_be,
    input  logic [ADDR_W-1:0]     c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    output logic                  c_ack,
    output logic [DATA_W-1:0]     c_rdata,
    output logic                  c_stall,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [DATA_W/8-1:0]   l_be,
    input  logic [ADDR_W-1:0]     l_addr,
    input  logic [DATA_W-1:0]     l_wdata,
    output logic                  l_ack,
    output logic [DATA_W-1:0]     l_rdata,
    output logic                  mem_wea,
    output logic [DATA_W/8-1:0]   mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic                  owner,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic [DATA_W/8-1:0]   r_be;
    logic                  r_last_grant;
    logic [DATA_W-1:0]     r_c_rdata;
    logic [DATA_W-1:0]     r_l_rdata;

    logic                  w_c_elig;
    logic                  w_grant_l;
    logic                  w_rd_done;
    logic                  w_c_rd_done;
    logic                  w_l_rd_done;

    // Arbitration: the loader wins when it is the only eligible requester, or
    // on a tie when the core had the previous grant.
    assign w_c_elig  = c_req & ~prog;
    assign w_grant_l = l_req & (~w_c_elig | ~r_last_grant);

    // A read with no byte enables is a no-op and must not disturb rdata.
    assign w_rd_done   = (r_state == S_RESP) & ~r_we & (|r_be);
    assign w_c_rd_done = w_rd_done & ~owner;
    assign w_l_rd_done = w_rd_done & owner;

    // mem_dout is the memory's own output register, so it is forwarded during
    // the ack cycle; the local registers then hold it until the next read.
    assign c_rdata = w_c_rd_done ? mem_dout : r_c_rdata;
    assign l_rdata = w_l_rd_done ? mem_dout : r_l_rdata;

    assign c_stall = prog | (c_req & ~c_ack);
    assign busy    = (r_state != S_IDLE);

    // Sequencer: arbitration, capture, memory strobes, acks and read data.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_last_grant <= 1'b1;
            r_c_rdata    <= '0;
            r_l_rdata    <= '0;
            c_ack        <= 1'b0;
            l_ack        <= 1'b0;
            mem_wea      <= 1'b0;
            mem_en       <= '0;
            mem_addr     <= '0;
            mem_din      <= '0;
            owner        <= 1'b0;
        end else begin
            c_ack   <= 1'b0;
            l_ack   <= 1'b0;
            mem_wea <= 1'b0;
            mem_en  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_c_elig || l_req) begin
                        owner    <= w_grant_l;
                        r_we     <= w_grant_l ? l_we    : c_we;
                        r_be     <= w_grant_l ? l_be    : c_be;
                        mem_addr <= w_grant_l ? l_addr  : c_addr;
                        mem_din  <= w_grant_l ? l_wdata : c_wdata;
                        mem_wea  <= w_grant_l ? l_we    : c_we;
                        mem_en   <= w_grant_l ? l_be    : c_be;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    c_ack   <= ~owner;
                    l_ack   <= owner;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (w_c_rd_done) r_c_rdata <= mem_dout;
                    if (w_l_rd_done) r_l_rdata <= mem_dout;
                    r_last_grant <= owner;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-enable memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        Rst, prog;
    logic        c_req, c_we, c_ack, c_stall;
    logic [3:0]  c_be;
    logic [11:0] c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        l_req, l_we, l_ack;
    logic [3:0]  l_be;
    logic [11:0] l_addr;
    logic [31:0] l_wdata, l_rdata;
    logic        mem_wea, owner, busy;
    logic [3:0]  mem_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = '0;

    logic [31:0] mem [0:1023];

    int n_cmp = 0;
    int n_err = 0;

    // values recorded by txn()
    logic [3:0]  s_en;
    logic        s_wea, s_busy, s_owner, s_stall;
    logic [11:0] s_addr;
    logic [31:0] s_rd;
    int          s_lat;
    logic        saw_cack, saw_nostall, saw_ack;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .Rst(Rst), .prog(prog),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_stall(c_stall),
        .l_req(l_req), .l_we(l_we), .l_be(l_be), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .mem_wea(mem_wea), .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .owner(owner), .busy(busy)
    );

    // 1-cycle synchronous-read memory with per-byte write enables
    always @(posedge clk) begin
        if (|mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_wea && mem_en[b])
                    mem[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
            mem_dout <= mem[mem_addr[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the core (ldr=0) or loader (ldr=1) bundle. Returns in
    // the IDLE cycle after RESP with the request dropped.
    task automatic txn(input bit ldr, input logic we, input logic [3:0] be,
                       input logic [11:0] addr, input logic [31:0] wd);
        if (ldr) begin
            l_we = we; l_be = be; l_addr = addr; l_wdata = wd; l_req = 1'b1;
        end else begin
            c_we = we; c_be = be; c_addr = addr; c_wdata = wd; c_req = 1'b1;
        end
        s_lat = -1;
        s_rd  = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (!c_stall) saw_nostall = 1'b1;
            if (ldr && c_ack) saw_cack = 1'b1;
            if (i == 1) begin
                s_en = mem_en; s_wea = mem_wea; s_addr = mem_addr;
                s_busy = busy; s_owner = owner; s_stall = c_stall;
            end
            if (ldr ? l_ack : c_ack) begin
                s_lat = i;
                s_rd  = ldr ? l_rdata : c_rdata;
                break;
            end
        end
        if (ldr) l_req = 1'b0; else c_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        Rst = 1'b0; prog = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_be = '0; c_addr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_be = '0; l_addr = '0; l_wdata = '0;
        saw_cack = 1'b0; saw_nostall = 1'b0; saw_ack = 1'b0;

        // reset state
        #2;
        chk("rst_c_ack",   {31'd0, c_ack},   32'd0);
        chk("rst_l_ack",   {31'd0, l_ack},   32'd0);
        chk("rst_c_rdata", c_rdata,          32'd0);
        chk("rst_mem_en",  {28'd0, mem_en},  32'd0);
        chk("rst_owner",   {31'd0, owner},   32'd0);
        chk("rst_busy",    {31'd0, busy},    32'd0);
        chk("rst_c_stall", {31'd0, c_stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1 Rst = 1'b1;
        tick();

        // core full-word write, then read back
        txn(0, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF);
        chk("wr_lat",   s_lat,              32'd2);
        chk("wr_en",    {28'd0, s_en},      32'hF);
        chk("wr_wea",   {31'd0, s_wea},     32'd1);
        chk("wr_addr",  {20'd0, s_addr},    32'h010);
        chk("wr_busy",  {31'd0, s_busy},    32'd1);
        chk("wr_stall", {31'd0, s_stall},   32'd1);
        txn(0, 1'b0, 4'hF, 12'h010, 32'h0);
        chk("rd_lat",   s_lat,              32'd2);
        chk("rd_wea",   {31'd0, s_wea},     32'd0);
        chk("rd_ack_data", s_rd,            32'hDEADBEEF);
        chk("rd_held",  c_rdata,            32'hDEADBEEF);

        // byte-lane merge
        txn(0, 1'b1, 4'hF, 12'h020, 32'h11223344);
        txn(0, 1'b1, 4'b0010, 12'h020, 32'h0000AA00);
        chk("bw_en",    {28'd0, s_en},      32'h2);
        txn(0, 1'b0, 4'hF, 12'h020, 32'h0);
        chk("bw_rdata", c_rdata,            32'h1122AA44);

        // be=0 read: acknowledged, no strobe, rdata untouched
        txn(0, 1'b0, 4'h0, 12'h010, 32'h0);
        chk("be0_lat",  s_lat,              32'd2);
        chk("be0_en",   {28'd0, s_en},      32'h0);
        chk("be0_rdata", c_rdata,           32'h1122AA44);

        // fresh reset so the first tie goes to the core
        Rst = 1'b0;
        #1;
        chk("rst2_c_rdata", c_rdata,        32'd0);
        tick();
        Rst = 1'b1;
        tick();

        // contention: both held, grants alternate core/loader
        c_we = 1'b0; c_be = 4'hF; c_addr = 12'h020;
        l_we = 1'b0; l_be = 4'hF; l_addr = 12'h010;
        c_req = 1'b1; l_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (c_ack || l_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            if (k == 3) begin
                c_req = 1'b0; l_req = 1'b0;
            end
            chk($sformatf("rr_got_%0d", k), {31'd0, got}, 32'd1);
            chk($sformatf("rr_ack_%0d", k), {30'd0, c_ack, l_ack},
                (k % 2 == 0) ? 32'd2 : 32'd1);
            if (k == 0) chk("rr_c_rdata", c_rdata, 32'h1122AA44);
            if (k == 1) chk("rr_l_rdata", l_rdata, 32'hDEADBEEF);
        end
        tick();
        tick();
        chk("rr_idle_busy", {31'd0, busy}, 32'd0);

        // program mode: loader fills 0x000..0x00C while core read is pending
        prog = 1'b1;
        c_we = 1'b0; c_be = 4'hF; c_addr = 12'h004; c_req = 1'b1;
        saw_cack = 1'b0; saw_nostall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b1, 4'hF, 12'(4 * i), 32'hA0000000 + 32'(i));
            chk($sformatf("pg_owner_%0d", i), {31'd0, s_owner}, 32'd1);
        end
        chk("pg_no_cack", {31'd0, saw_cack},    32'd0);
        chk("pg_stall",   {31'd0, saw_nostall}, 32'd0);
        prog = 1'b0;
        txn(0, 1'b0, 4'hF, 12'h004, 32'h0);
        chk("pg_core_lat",   s_lat,           32'd2);
        chk("pg_core_owner", {31'd0, s_owner}, 32'd0);
        chk("pg_core_rdata", s_rd,            32'hA0000001);

        // prog rises while the core is in ISSUE
        c_we = 1'b0; c_be = 4'hF; c_addr = 12'h008; c_req = 1'b1;
        tick();
        chk("pr_iss_owner", {31'd0, owner}, 32'd0);
        prog = 1'b1;
        l_we = 1'b0; l_be = 4'hF; l_addr = 12'h00C; l_req = 1'b1;
        tick();
        chk("pr_c_ack",   {30'd0, c_ack, l_ack}, 32'd2);
        chk("pr_c_rdata", c_rdata,               32'hA0000002);
        c_req = 1'b0;
        tick();
        tick();
        chk("pr_l_owner", {31'd0, owner},     32'd1);
        chk("pr_l_addr",  {20'd0, mem_addr},  32'h00C);
        tick();
        chk("pr_l_ack",   {30'd0, c_ack, l_ack}, 32'd1);
        chk("pr_l_rdata", l_rdata,               32'hA0000003);
        l_req = 1'b0; prog = 1'b0;
        tick();

        // asynchronous reset in the middle of a core read ISSUE
        c_we = 1'b0; c_be = 4'hF; c_addr = 12'h010; c_req = 1'b1;
        tick();
        chk("ar_iss_en", {28'd0, mem_en}, 32'hF);
        #2 Rst = 1'b0;
        #1;
        chk("ar_en",      {28'd0, mem_en},   32'h0);
        chk("ar_busy",    {31'd0, busy},     32'd0);
        chk("ar_owner",   {31'd0, owner},    32'd0);
        chk("ar_addr",    {20'd0, mem_addr}, 32'h0);
        chk("ar_l_rdata", l_rdata,           32'd0);
        chk("ar_c_rdata", c_rdata,           32'd0);
        c_req = 1'b0;
        @(posedge clk);
        #1 Rst = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (c_ack || l_ack) saw_ack = 1'b1;
        end
        chk("ar_no_ack", {31'd0, saw_ack}, 32'd0);
        txn(0, 1'b0, 4'hF, 12'h010, 32'h0);
        chk("ar_rd_lat",   s_lat, 32'd2);
        chk("ar_rd_rdata", s_rd,  32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
